// File: rtl/atm_pkg.sv
// Shared ATM cell definitions: cell geometry, translator FSM states and the
// bit positions of the VCI and forwarding-table fields.
package atm_pkg;

  localparam int CELL_LEN = 53;
  localparam int HDR_LEN  = 5;
  localparam int CNT_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LKP,
    WAIT,
    EMIT,
    PAY,
    DROP
  } state_t;

  // Where the 16-bit VCI sits across header bytes 1..3
  localparam int B1_VCI_HI = 15;
  localparam int B1_VCI_LO = 12;
  localparam int B2_VCI_HI = 11;
  localparam int B2_VCI_LO = 4;
  localparam int B3_VCI_HI = 3;
  localparam int B3_VCI_LO = 0;

  localparam int FWD_PORT_HI = 19;
  localparam int FWD_PORT_LO = 16;
  localparam int FWD_VCI_HI  = 15;
  localparam int FWD_VCI_LO  = 0;

  // Only the header fields that survive translation or feed the lookup
  typedef struct packed {
    logic [7:0] byte0;
    logic [3:0] vpi_lo;
    logic [7:0] vci_lo;
    logic [3:0] pti_clp;
  } hdr_t;

endpackage

// File: rtl/hdr_xlate.sv
// ATM header translator: captures the cell header, looks up the VCI in an
// external forwarding table, rewrites the VCI and forwards or drops the cell.
module hdr_xlate #(
  parameter int CELL_LEN = atm_pkg::CELL_LEN,
  parameter int DROP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [7:0]        out_data,
  output logic [3:0]        out_port,
  input  logic              out_ready,
  output logic              fwd_rden,
  output logic [7:0]        fwd_addr,
  input  logic [19:0]       fwd_data,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              err_sop
);
  import atm_pkg::*;

  localparam logic [CNT_W-1:0] HDR_LAST_CNT = CNT_W'(HDR_LEN - 2);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CELL_LEN - 2);
  localparam logic [2:0]       EMIT_LAST    = 3'(HDR_LEN - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         emit_q, emit_d;
  hdr_t               hdr_q, hdr_d;
  logic [15:0]        vci_q, vci_d;
  logic [3:0]         port_q, port_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               err_q, err_d;
  logic               in_ready_c;
  logic               last_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      emit_q  <= '0;
      hdr_q   <= '0;
      vci_q   <= '0;
      port_q  <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      emit_q  <= emit_d;
      hdr_q   <= hdr_d;
      vci_q   <= vci_d;
      port_q  <= port_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  // cnt_q counts bytes accepted after the sop byte, so the last payload
  // byte arrives while cnt_q == CELL_LEN-2.
  assign last_byte = (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    emit_d     = emit_q;
    hdr_d      = hdr_q;
    vci_d      = vci_q;
    port_d     = port_q;
    drop_d     = drop_q;
    err_d      = 1'b0;
    in_ready_c = 1'b0;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_data   = 8'h00;
    fwd_rden   = 1'b0;
    fwd_addr   = 8'h00;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid && in_sop) begin
          hdr_d.byte0 = in_data;
          cnt_d       = '0;
          state_d     = HDR;
        end
      end

      HDR: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          err_d = in_sop;
          case (cnt_q)
            CNT_W'(0): hdr_d.vpi_lo = in_data[7:4];
            CNT_W'(1): hdr_d.vci_lo[7:4] = in_data[3:0];
            CNT_W'(2): begin
              hdr_d.vci_lo[3:0] = in_data[7:4];
              hdr_d.pti_clp     = in_data[3:0];
            end
            default: ;
          endcase
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == HDR_LAST_CNT) state_d = LKP;
        end
      end

      LKP: begin
        fwd_rden = 1'b1;
        fwd_addr = hdr_q.vci_lo;
        state_d  = WAIT;
      end

      WAIT: begin
        port_d = fwd_data[FWD_PORT_HI:FWD_PORT_LO];
        vci_d  = fwd_data[FWD_VCI_HI:FWD_VCI_LO];
        emit_d = 3'd0;
        if (fwd_data[FWD_PORT_HI:FWD_PORT_LO] == 4'h0) begin
          state_d = DROP;
          if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end else begin
          state_d = EMIT;
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        out_sop   = (emit_q == 3'd0);
        case (emit_q)
          3'd0:    out_data = hdr_q.byte0;
          3'd1:    out_data = {hdr_q.vpi_lo, vci_q[B1_VCI_HI:B1_VCI_LO]};
          3'd2:    out_data = vci_q[B2_VCI_HI:B2_VCI_LO];
          3'd3:    out_data = {vci_q[B3_VCI_HI:B3_VCI_LO], hdr_q.pti_clp};
          default: out_data = 8'h00;
        endcase
        if (out_ready) begin
          emit_d = emit_q + 3'd1;
          if (emit_q == EMIT_LAST) state_d = PAY;
        end
      end

      PAY: begin
        in_ready_c = out_ready;
        out_valid  = in_valid;
        out_data   = in_data;
        out_eop    = in_valid && last_byte;
        if (in_valid && out_ready) begin
          err_d = in_sop;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_byte) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end

      DROP: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          err_d = in_sop;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_byte) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Upstream must see not-ready while reset is held, even though IDLE is open
  assign in_ready = in_ready_c & ~rst;
  assign out_port = port_q;
  assign drop_cnt = drop_q;
  assign err_sop  = err_q;

endmodule

// File: tb/tb_hdr_xlate.sv
// Self-checking bench for hdr_xlate: fixed header vectors, corner-case
// sequences and randomized cells checked against a cell-level model.
module tb_hdr_xlate;

  localparam int CLEN     = 53;
  localparam int DROP_MAX = 15;

  logic        clk, rst;
  logic        in_valid, in_sop, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_sop, out_eop, out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_port;
  logic        fwd_rden;
  logic [7:0]  fwd_addr;
  logic [19:0] fwd_data;
  logic [3:0]  drop_cnt;
  logic        err_sop;

  hdr_xlate #(.CELL_LEN(CLEN), .DROP_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_port(out_port), .out_ready(out_ready),
    .fwd_rden(fwd_rden), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .drop_cnt(drop_cnt), .err_sop(err_sop)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [3:0] port;
  } obyte_t;

  typedef struct packed {
    logic [39:0] hin;
    logic [19:0] entry;
    logic [7:0]  addr;
    logic [31:0] hout;
    logic [3:0]  port;
    logic        drop;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int out_mode = 0;
  bit mirror_en = 0;

  logic [19:0] fwd_mem [256];
  logic [7:0]  cb [CLEN];
  vec_t        vecs [4];

  obyte_t      got_q[$];
  obyte_t      exp_q[$];
  logic [7:0]  got_addr_q[$];
  int          sop_cyc_q[$];
  logic [1:0]  mirror_q[$];
  int          err_cnt = 0;
  logic        sop_prev = 1'b0;
  int          out_idx = 0;

  int got_base = 0, addr_base = 0, sop_base = 0, mirror_base = 0;
  int acc4_cyc = 0;
  int exp_addr = 0;
  int model_drops = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous forwarding table with one cycle read latency
  always @(posedge clk) if (fwd_rden) fwd_data <= fwd_mem[fwd_addr];

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      out_idx  <= 0;
      sop_prev <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        got_q.push_back('{out_data, out_sop, out_eop, out_port});
        if (out_eop)      out_idx <= 0;
        else if (out_sop) out_idx <= 1;
        else              out_idx <= out_idx + 1;
      end
      if (fwd_rden) got_addr_q.push_back(fwd_addr);
      if (out_valid && out_sop && !sop_prev) sop_cyc_q.push_back(cyc);
      sop_prev <= out_valid && out_sop;
      if (err_sop) err_cnt <= err_cnt + 1;
      if (mirror_en && out_valid && out_idx >= 5) mirror_q.push_back({in_ready, out_ready});
    end
  end

  initial begin
    #900000;
    $display("[TB] watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] d, input logic s, output int acc_cyc);
    int  n;
    bit  done;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    n        = 0;
    done     = 0;
    acc_cyc  = -1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        done    = 1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 300) begin
        checkOutput("in_ready timeout", 32'(in_ready), 32'h1);
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic applyStimulus(input int n_bytes, input int sop_at, input int bubble_pct);
    int ac;
    for (int k = 0; k < n_bytes; k++) begin
      if (bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      sendByte(cb[k], (k == 0) || (k == sop_at), ac);
      if (k == 4) acc4_cyc = ac;
    end
  endtask

  task automatic pushExp(input logic [7:0] d, input logic s, input logic e, input logic [3:0] p);
    exp_q.push_back('{d, s, e, p});
  endtask

  // Cell-level reference: VCI is the 16-bit field at bits [19:4] of the
  // first four header bytes viewed as one 32-bit word.
  task automatic modelCell();
    logic [31:0] w;
    logic [15:0] vci;
    logic [19:0] e;
    w        = {cb[0], cb[1], cb[2], cb[3]};
    vci      = w[19:4];
    exp_addr = int'(vci[7:0]);
    e        = fwd_mem[vci[7:0]];
    exp_q.delete();
    if (e[19:16] == 4'h0) begin
      model_drops = (model_drops >= DROP_MAX) ? DROP_MAX : model_drops + 1;
    end else begin
      w[19:4] = e[15:0];
      pushExp(w[31:24], 1'b1, 1'b0, e[19:16]);
      pushExp(w[23:16], 1'b0, 1'b0, e[19:16]);
      pushExp(w[15:8],  1'b0, 1'b0, e[19:16]);
      pushExp(w[7:0],   1'b0, 1'b0, e[19:16]);
      pushExp(8'h00,    1'b0, 1'b0, e[19:16]);
      for (int k = 5; k < CLEN; k++) pushExp(cb[k], 1'b0, k == CLEN - 1, e[19:16]);
    end
  endtask

  task automatic setupVector(input int v);
    vec_t t;
    t = vecs[v];
    for (int k = 0; k < 5; k++) cb[k] = t.hin[39 - 8*k -: 8];
    for (int k = 5; k < CLEN; k++) cb[k] = 8'(k * 3 + v);
    fwd_mem[t.addr] = t.entry;
    exp_addr = int'(t.addr);
    exp_q.delete();
    if (t.drop) begin
      model_drops = (model_drops >= DROP_MAX) ? DROP_MAX : model_drops + 1;
    end else begin
      for (int k = 0; k < 4; k++) pushExp(t.hout[31 - 8*k -: 8], k == 0, 1'b0, t.port);
      pushExp(8'h00, 1'b0, 1'b0, t.port);
      for (int k = 5; k < CLEN; k++) pushExp(cb[k], 1'b0, k == CLEN - 1, t.port);
    end
  endtask

  task automatic randomHeader();
    for (int k = 0; k < CLEN; k++) cb[k] = 8'($urandom);
  endtask

  task automatic checkCell(input string name);
    int n, ng, lat;
    logic [31:0] a;
    n = 0;
    while ((got_q.size() - got_base) < exp_q.size() && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    ng = got_q.size() - got_base;
    checkOutput({name, " byte count"}, 32'(ng), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ng; i++)
      checkOutput($sformatf("%s byte %0d", name, i), 32'(got_q[got_base + i]), 32'(exp_q[i]));
    a = (got_addr_q.size() > addr_base) ? 32'(got_addr_q[addr_base]) : 32'hFFFF_FFFF;
    checkOutput({name, " fwd_addr"}, a, 32'(exp_addr));
    if (exp_q.size() != 0) begin
      lat = (sop_cyc_q.size() > sop_base) ? sop_cyc_q[sop_base] - acc4_cyc : -1;
      checkOutput({name, " sop latency"}, 32'(lat), 32'd3);
    end
    checkOutput({name, " drop_cnt"}, 32'(drop_cnt), 32'(model_drops));
    got_base  = got_q.size();
    addr_base = got_addr_q.size();
    sop_base  = sop_cyc_q.size();
    exp_q.delete();
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, " in_ready"},  32'(in_ready),  32'h0);
    checkOutput({name, " out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({name, " out_flags"}, 32'({out_sop, out_eop, out_data}), 32'h0);
    checkOutput({name, " fwd"},       32'({fwd_rden, fwd_addr}), 32'h0);
    checkOutput({name, " out_port"},  32'(out_port),  32'h0);
    checkOutput({name, " drop_cnt"},  32'(drop_cnt),  32'h0);
    checkOutput({name, " err_sop"},   32'(err_sop),   32'h0);
  endtask

  initial begin
    int ac, err_before;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 8'h00;
    for (int a = 0; a < 256; a++) fwd_mem[a] = 20'h0;

    vecs[0] = '{40'hA5_60_01_2B_77, 20'h3ABCD, 8'h12, 32'hA5_6A_BC_DB, 4'h3, 1'b0};
    vecs[1] = '{40'h00_00_03_40_11, 20'h05555, 8'h34, 32'h0000_0000, 4'h0, 1'b1};
    vecs[2] = '{40'hFF_FF_FF_FF_22, 20'h80000, 8'hFF, 32'hFF_F0_00_0F, 4'h8, 1'b0};
    vecs[3] = '{40'h3C_95_E7_18_33, 20'hF1234, 8'h71, 32'h3C_91_23_48, 4'hF, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      setupVector(v);
      applyStimulus(CLEN, -1, 0);
      checkCell($sformatf("vec%0d", v));
    end

    out_mode    = 1;
    mirror_en   = 1;
    mirror_base = mirror_q.size();
    for (int k = 0; k < 5; k++) cb[k] = vecs[0].hin[39 - 8*k -: 8];
    for (int k = 5; k < CLEN; k++) cb[k] = 8'($urandom);
    modelCell();
    applyStimulus(CLEN, -1, 0);
    checkCell("toggle");
    mirror_en = 0;
    checkOutput("mirror samples", 32'(mirror_q.size() - mirror_base >= CLEN - 5), 32'h1);
    for (int i = mirror_base; i < mirror_q.size(); i++)
      checkOutput($sformatf("in_ready mirror %0d", i - mirror_base), 32'(mirror_q[i][1]), 32'(mirror_q[i][0]));
    out_mode = 0;

    err_before = err_cnt;
    for (int k = 0; k < 5; k++) cb[k] = vecs[2].hin[39 - 8*k -: 8];
    for (int k = 5; k < CLEN; k++) cb[k] = 8'($urandom);
    modelCell();
    applyStimulus(CLEN, 24, 0);
    repeat (2) @(posedge clk);
    #1;
    checkCell("mid sop");
    checkOutput("mid sop err pulses", 32'(err_cnt - err_before), 32'h1);

    for (int a = 0; a < 256; a++)
      fwd_mem[a] = {($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15, 1)), 16'($urandom)};
    out_mode   = 2;
    err_before = err_cnt;
    for (int r = 0; r < 30; r++) begin
      randomHeader();
      modelCell();
      applyStimulus(CLEN, -1, 20);
      checkCell($sformatf("rand%0d", r));
    end
    checkOutput("random err pulses", 32'(err_cnt - err_before), 32'h0);
    out_mode = 0;

    for (int k = 0; k < 5; k++) cb[k] = vecs[0].hin[39 - 8*k -: 8];
    for (int k = 5; k < CLEN; k++) cb[k] = 8'($urandom);
    fwd_mem[8'h12] = 20'h3ABCD;
    applyStimulus(29, -1, 0);
    in_valid = 1'b1;
    in_data  = cb[29];
    rst      = 1'b1;
    @(negedge clk);
    checkReset("mid-cell reset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    got_base    = got_q.size();
    addr_base   = got_addr_q.size();
    sop_base    = sop_cyc_q.size();
    model_drops = 0;
    for (int j = 0; j < 3; j++) sendByte(8'($urandom), 1'b0, ac);
    randomHeader();
    modelCell();
    applyStimulus(CLEN, -1, 0);
    checkCell("after reset");

    fwd_mem[8'h34] = 20'h05555;
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < 5; k++) cb[k] = vecs[1].hin[39 - 8*k -: 8];
      for (int k = 5; k < CLEN; k++) cb[k] = 8'($urandom);
      modelCell();
      applyStimulus(CLEN, -1, 0);
      checkCell($sformatf("sat%0d", i));
    end
    checkOutput("drop_cnt saturated", 32'(drop_cnt), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
